fetch_stage: RTL

Instruction-fetch stage of the 5-stage 16-bit pipeline. Holds the PC, drives the variable-latency instruction memory, and presents one fetched instruction per cycle to the fetch→decode pipeline register, with a one-entry skid buffer so decode back-pressure never drops a returned word. Takes branch/jump redirects from execute and stops fetching after a HALT.

---
 rtl/fetch_stage.sv | 98 +++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC, variable-latency instruction fetch with one-entry skid, redirect squash.
// Optional HALT stop when FETCH_HALT_DETECT_EN is defined.
module fetch_stage (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [15:0] RedirectPc,
  output logic        MemRd,
  output logic [15:0] MemAddr,
  input  logic        MemDone,
  input  logic [15:0] MemData,
  output logic [15:0] Instruction,
  output logic [15:0] PcPlus2,
  output logic        InstValid,
  output logic        Halted,
  output logic        Err
);
  typedef enum logic [1:0] {IDLE, WAIT, FULL, HALT} state_t;
  state_t state, stateNext;
  logic live, squash, outValid, done, accept, toSkid, memHalt, skidHalt;
  logic [15:0] pc, pcPlus2, target, redirTarget, outInst, outPc2, skidInst, skidPc2;
`ifdef FETCH_HALT_DETECT_EN
  assign memHalt = MemData[15:11] == 5'b00000;
  assign skidHalt = skidInst[15:11] == 5'b00000;
`else
  assign memHalt = 1'b0;
  assign skidHalt = 1'b0;
`endif
  // live keeps MemRd low in the first cycle after reset
  assign MemRd = live && (state == IDLE || state == WAIT);
  assign MemAddr = pc;
  assign pcPlus2 = pc + 16'd2;
  assign done = MemRd && MemDone;
  assign accept = done && !squash;
  assign toSkid = accept && outValid && Stall;
  assign redirTarget = {RedirectPc[15:1], 1'b0};
  assign Instruction = outValid ? outInst : 16'h0800;
  assign PcPlus2 = outPc2;
  assign InstValid = outValid;
  assign Halted = state == HALT;
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) state <= IDLE;
    else state <= stateNext;
  always_comb begin
    stateNext = state;
    if (Redirect) stateNext = (MemRd && !MemDone) ? WAIT : IDLE;
    else if (state == FULL) stateNext = Stall ? FULL : skidHalt ? HALT : IDLE;
    else if (done) stateNext = squash ? IDLE : toSkid ? FULL : memHalt ? HALT : IDLE;
    else if (MemRd) stateNext = WAIT;
  end
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      live <= 1'b0;
      squash <= 1'b0;
      outValid <= 1'b0;
      Err <= 1'b0;
      pc <= '0;
      target <= '0;
      outInst <= '0;
      outPc2 <= '0;
      skidInst <= '0;
      skidPc2 <= '0;
    end else begin
      live <= 1'b1;
      if (Redirect) begin
        Err <= Err | RedirectPc[0];
        outValid <= 1'b0;
        squash <= MemRd && !MemDone;
        // an in-flight request keeps its address; the target waits until its data is dropped
        if (MemRd && !MemDone) target <= redirTarget;
        else pc <= redirTarget;
      end else begin
        if (!Stall) outValid <= 1'b0;
        if (state == FULL && !Stall) begin
          outValid <= 1'b1;
          outInst <= skidInst;
          outPc2 <= skidPc2;
        end
        if (done && squash) begin
          squash <= 1'b0;
          pc <= target;
        end
        if (accept) begin
          pc <= pcPlus2;
          if (toSkid) begin
            skidInst <= MemData;
            skidPc2 <= pcPlus2;
          end else begin
            outValid <= 1'b1;
            outInst <= MemData;
            outPc2 <= pcPlus2;
          end
        end
      end
    end
  end
endmodule
